lfm_step_tracker: RTL and testbench

- Receive-side companion to the stepped LFM foldback generator.
- Consumes the DDS output phase stream (32-bit accumulator phase, one sample per valid) and recovers the instantaneous phase increment by first differencing.
- Segments the stream into constant-frequency dwells and reports, for each completed dwell, its frequency word, its length, the step direction and foldback (direction-reversal) events.
- Used for loopback self-check of the LFM chain and for in-system sweep monitoring.

---
 rtl/lfm_step_tracker_if.sv | 37 +++
 rtl/lfm_step_tracker.sv | 138 +++++++++++++
 tb/tb_lfm_step_tracker.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lfm_step_tracker_if.sv
// Phase-stream input and dwell-report output bundle for lfm_step_tracker.
// freq_min/freq_max exist only when LFM_TRACK_MINMAX_EN is defined.
interface lfm_step_tracker_if #(
  parameter int unsigned DWELL_W = 16,
  parameter int unsigned STEP_W  = 8
);
  logic               s_phase_valid;
  logic [31:0]        s_phase_data;
  logic               freq_valid;
  logic [31:0]        freq_data;
  logic [DWELL_W-1:0] dwell_len;
  logic [1:0]         dir;
  logic               fold_pulse;
  logic [STEP_W-1:0]  step_count;
`ifdef LFM_TRACK_MINMAX_EN
  logic [31:0]        freq_min;
  logic [31:0]        freq_max;
`endif

  modport slave (
`ifdef LFM_TRACK_MINMAX_EN
    output freq_min, output freq_max,
`endif
    input  s_phase_valid, input s_phase_data,
    output freq_valid, output freq_data, output dwell_len,
    output dir, output fold_pulse, output step_count
  );

  modport master (
`ifdef LFM_TRACK_MINMAX_EN
    input  freq_min, input freq_max,
`endif
    output s_phase_valid, output s_phase_data,
    input  freq_valid, input freq_data, input dwell_len,
    input  dir, input fold_pulse, input step_count
  );
endinterface

// File: rtl/lfm_step_tracker.sv
// Recovers the phase increment of a DDS phase stream and reports each completed constant-frequency dwell.
// Optional LFM_TRACK_MINMAX_EN adds running unsigned min/max of reported frequency words.
//
// state | meaning
// IDLE  | no previous phase held yet
// PRIME | previous phase held, waiting for first difference to seed ref
// TRACK | ref valid, counting dwell length and detecting steps
module lfm_step_tracker #(
  parameter logic [31:0] TOL     = 32'h0001_0000,
  parameter int unsigned DWELL_W = 16,
  parameter int unsigned STEP_W  = 8
) (
  input logic          clk,
  input logic          reset,
  lfm_step_tracker_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PRIME, TRACK} state_t;

  state_t             r_state, w_state_nxt;
  logic [31:0]        r_prev_phase, r_diff, r_ref;
  logic               r_diff_valid;
  logic [DWELL_W-1:0] r_dwell_cnt;
  logic               r_freq_valid, r_fold_pulse;
  logic [31:0]        r_freq_data;
  logic [DWELL_W-1:0] r_dwell_len;
  logic [1:0]         r_dir;
  logic [STEP_W-1:0]  r_step_count;

  logic [31:0] w_d;
  logic [32:0] w_d_ext, w_abs;
  logic        w_prime, w_same, w_step, w_fold;
  logic [1:0]  w_new_dir;

  // 33-bit magnitude so that d = -2^31 compares as 2^31 instead of wrapping
  always_comb begin
    w_d     = r_diff - r_ref;
    w_d_ext = {w_d[31], w_d};
    w_abs   = w_d[31] ? (33'd0 - w_d_ext) : w_d_ext;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_prime     = 1'b0;
    w_same      = 1'b0;
    w_step      = 1'b0;
    w_fold      = 1'b0;
    w_new_dir   = w_d[31] ? 2'b01 : 2'b10;
    case (r_state)
      IDLE:  if (bus.s_phase_valid) w_state_nxt = PRIME;
      PRIME: if (r_diff_valid) begin
        w_prime     = 1'b1;
        w_state_nxt = TRACK;
      end
      TRACK: if (r_diff_valid) begin
        if (w_abs > {1'b0, TOL}) begin
          w_step = 1'b1;
          w_fold = (r_dir != 2'b00) && (w_new_dir != r_dir);
        end else begin
          w_same = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // r_dir doubles as last_dir: it only changes on a step event
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev_phase <= '0;
      r_diff       <= '0;
      r_diff_valid <= 1'b0;
      r_ref        <= '0;
      r_dwell_cnt  <= '0;
      r_freq_valid <= 1'b0;
      r_fold_pulse <= 1'b0;
      r_freq_data  <= '0;
      r_dwell_len  <= '0;
      r_dir        <= 2'b00;
      r_step_count <= '0;
    end else begin
      r_diff_valid <= 1'b0;
      if (bus.s_phase_valid) begin
        r_diff       <= bus.s_phase_data - r_prev_phase;
        r_prev_phase <= bus.s_phase_data;
        r_diff_valid <= (r_state != IDLE);
      end
      r_freq_valid <= w_step;
      r_fold_pulse <= w_fold;
      if (w_prime) begin
        r_ref       <= r_diff;
        r_dwell_cnt <= DWELL_W'(1);
      end else if (w_same) begin
        if (!(&r_dwell_cnt)) r_dwell_cnt <= r_dwell_cnt + DWELL_W'(1);
      end else if (w_step) begin
        r_freq_data  <= r_ref;
        r_dwell_len  <= r_dwell_cnt;
        r_dir        <= w_new_dir;
        r_step_count <= r_step_count + STEP_W'(1);
        r_ref        <= r_diff;
        r_dwell_cnt  <= DWELL_W'(1);
      end
    end
  end

  assign bus.freq_valid = r_freq_valid;
  assign bus.freq_data  = r_freq_data;
  assign bus.dwell_len  = r_dwell_len;
  assign bus.dir        = r_dir;
  assign bus.fold_pulse = r_fold_pulse;
  assign bus.step_count = r_step_count;

`ifdef LFM_TRACK_MINMAX_EN
  logic        r_mm_seen;
  logic [31:0] r_freq_min, r_freq_max;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mm_seen  <= 1'b0;
      r_freq_min <= '0;
      r_freq_max <= '0;
    end else if (w_step) begin
      r_mm_seen  <= 1'b1;
      r_freq_min <= (!r_mm_seen || (r_ref < r_freq_min)) ? r_ref : r_freq_min;
      r_freq_max <= (!r_mm_seen || (r_ref > r_freq_max)) ? r_ref : r_freq_max;
    end
  end

  assign bus.freq_min = r_freq_min;
  assign bus.freq_max = r_freq_max;
`endif

endmodule

// File: tb/tb_lfm_step_tracker.sv
// Self-checking bench for lfm_step_tracker: sample-level dwell model, per-cycle output compare, directed and random streams.
// Also checks freq_min/freq_max when LFM_TRACK_MINMAX_EN is defined.
module tb_lfm_step_tracker;
  localparam logic [31:0] TOL = 32'h0001_0000;
  localparam logic [31:0] INC_A = 32'h1999_999A;
  localparam logic [31:0] INC_B = 32'h170A_3D71;
  localparam logic [31:0] INC_C = 32'h1C28_F5C3;

  logic clk = 1'b0;
  logic reset = 1'b1;

  lfm_step_tracker_if bus ();

  lfm_step_tracker #(.TOL(TOL), .DWELL_W(16), .STEP_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] freq;
    int          len;
    logic [1:0]  dir;
    logic        fold;
    logic [7:0]  step;
  } rep_t;

  rep_t q[$];
  rep_t r;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;

  // sample-level model state
  bit          m_have_prev, m_have_ref;
  logic [31:0] m_prev, m_ref;
  int          m_cnt;
  logic [1:0]  m_last_dir;
  logic [7:0]  m_steps;

  // expected DUT outputs
  logic        e_fv, e_fold;
  logic [31:0] e_freq;
  int          e_len;
  logic [1:0]  e_dir;
  logic [7:0]  e_step;
  bit          e_seen;
  logic [31:0] e_min, e_max;

  int          m_rep_count = 0, m_fold_count = 0, rep_mark = 0, fold_mark = 0;
  logic [31:0] last_freq;
  int          last_len;
  logic [1:0]  last_dir;
  logic [7:0]  last_step;

  int pin_id = 0, pin_last = 0;
  bit tb_done = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_have_prev = 0; m_have_ref = 0; m_prev = '0; m_ref = '0; m_cnt = 0;
    m_last_dir = 2'b00; m_steps = '0;
    e_freq = '0; e_len = 0; e_dir = 2'b00; e_step = '0;
    e_seen = 0; e_min = '0; e_max = '0;
  endtask

  task automatic model_accept(input logic [31:0] p, input int due);
    logic [31:0] diff, dd;
    longint      d, ad;
    rep_t        nr;
    if (!m_have_prev) begin
      m_have_prev = 1; m_prev = p;
      return;
    end
    diff = p - m_prev;
    m_prev = p;
    if (!m_have_ref) begin
      m_have_ref = 1; m_ref = diff; m_cnt = 1;
      return;
    end
    dd = diff - m_ref;
    d  = longint'($signed(dd));
    ad = (d < 0) ? -d : d;
    if (ad > longint'(TOL)) begin
      nr.due  = due;
      nr.freq = m_ref;
      nr.len  = m_cnt;
      nr.dir  = (d < 0) ? 2'b01 : 2'b10;
      nr.fold = (m_last_dir != 2'b00) && (nr.dir != m_last_dir);
      m_steps = m_steps + 8'd1;
      nr.step = m_steps;
      q.push_back(nr);
      m_last_dir = nr.dir;
      m_ref = diff;
      m_cnt = 1;
    end else if (m_cnt < 65535) begin
      m_cnt++;
    end
  endtask

  task automatic do_pins(input int id);
    if (id % 2 == 1) begin
      rep_mark = m_rep_count; fold_mark = m_fold_count;
    end else begin
      case (id)
        2, 8: begin
          chk($sformatf("pin%0d_reports", id), 32'(m_rep_count - rep_mark), 32'd1);
          chk($sformatf("pin%0d_freq", id), last_freq, INC_A);
          chk($sformatf("pin%0d_len", id), 32'(last_len), 32'd49);
          chk($sformatf("pin%0d_dir", id), 32'(last_dir), 32'd1);
          chk($sformatf("pin%0d_folds", id), 32'(m_fold_count - fold_mark), 32'd0);
          chk($sformatf("pin%0d_step", id), 32'(last_step), 32'd1);
        end
        4: chk("pin_wrap_reports", 32'(m_rep_count - rep_mark), 32'd0);
        6: begin
          chk("pin_seq3_reports", 32'(m_rep_count - rep_mark), 32'd3);
          chk("pin_seq3_folds", 32'(m_fold_count - fold_mark), 32'd1);
          chk("pin_seq3_freq", last_freq, INC_C);
          chk("pin_seq3_len", 32'(last_len), 32'd20);
          chk("pin_seq3_dir", 32'(last_dir), 32'd1);
          chk("pin_seq3_step", 32'(last_step), 32'd3);
        end
        10: begin
          chk("pin_bound_reports", 32'(m_rep_count - rep_mark), 32'd4);
          chk("pin_bound_folds", 32'(m_fold_count - fold_mark), 32'd2);
          chk("pin_bound_freq", last_freq, 32'd0);
          chk("pin_bound_len", 32'(last_len), 32'd5);
          chk("pin_bound_dir", 32'(last_dir), 32'd2);
        end
        12: begin
          chk("pin_rstmid_reports", 32'(m_rep_count - rep_mark), 32'd1);
          chk("pin_rstmid_step", 32'(last_step), 32'd1);
        end
        default: ;
      endcase
    end
  endtask

  always @(posedge clk) begin
    edge_n++;
    if (reset) model_reset();
    else if (bus.s_phase_valid) model_accept(bus.s_phase_data, edge_n + 1);
    #1;
    e_fv = 1'b0; e_fold = 1'b0;
    if (q.size() > 0 && q[0].due == edge_n) begin
      r = q.pop_front();
      e_fv = 1'b1; e_fold = r.fold; e_freq = r.freq; e_len = r.len;
      e_dir = r.dir; e_step = r.step;
      if (!e_seen || r.freq < e_min) e_min = r.freq;
      if (!e_seen || r.freq > e_max) e_max = r.freq;
      e_seen = 1;
      m_rep_count++;
      if (r.fold) m_fold_count++;
      last_freq = r.freq; last_len = r.len; last_dir = r.dir; last_step = r.step;
    end
    chk("freq_valid", 32'(bus.freq_valid), 32'(e_fv));
    chk("fold_pulse", 32'(bus.fold_pulse), 32'(e_fold));
    chk("freq_data", bus.freq_data, e_freq);
    chk("dwell_len", 32'(bus.dwell_len), 32'(e_len));
    chk("dir", 32'(bus.dir), 32'(e_dir));
    chk("step_count", 32'(bus.step_count), 32'(e_step));
`ifdef LFM_TRACK_MINMAX_EN
    chk("freq_min", bus.freq_min, e_min);
    chk("freq_max", bus.freq_max, e_max);
`endif
    if (pin_id != pin_last) begin
      do_pins(pin_id);
      pin_last = pin_id;
    end
    if (tb_done) begin
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] ph;

  task automatic send(input logic [31:0] p, input int gap);
    @(negedge clk);
    bus.s_phase_valid = 1'b1;
    bus.s_phase_data  = p;
    repeat (gap) begin
      @(negedge clk);
      bus.s_phase_valid = 1'b0;
      bus.s_phase_data  = $urandom;
    end
  endtask

  task automatic run(input logic [31:0] inc, input int n, input int gap, input int jit);
    logic [31:0] j;
    for (int i = 0; i < n; i++) begin
      ph = ph + inc;
      j = 32'($urandom_range(0, 2 * jit)) - 32'(jit);
      send(ph + j, (gap < 0) ? int'($urandom_range(0, 2)) : gap);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.s_phase_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic flush();
    @(negedge clk);
    bus.s_phase_valid = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic pin(input int id);
    @(negedge clk);
    bus.s_phase_valid = 1'b0;
    pin_id = id;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] inc, prev_inc;
    bus.s_phase_valid = 1'b0;
    bus.s_phase_data  = '0;
    // reset held while the input toggles
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.s_phase_valid = ~bus.s_phase_valid;
      bus.s_phase_data  = $urandom;
    end
    @(negedge clk);
    reset = 1'b0;
    bus.s_phase_valid = 1'b0;

    // 50 samples at A, 10 at B
    do_reset(); pin(1);
    ph = $urandom; send(ph, 0);
    run(INC_A, 49, 0, 0); run(INC_B, 10, 0, 0);
    flush(); pin(2);

    // wrap with jitter
    do_reset(); pin(3);
    ph = 32'hF000_0000; send(ph + 32'h0000_0080, 0);
    run(32'h2000_0000, 39, 0, 32'h100);
    flush(); pin(4);

    // B, A, C, B dwells
    do_reset(); pin(5);
    ph = $urandom; send(ph, 0);
    run(INC_B, 20, 0, 0); run(INC_A, 20, 0, 0); run(INC_C, 20, 0, 0); run(INC_B, 5, 0, 0);
    flush(); pin(6);

    // first scenario with valid every other cycle
    do_reset(); pin(7);
    ph = $urandom; send(ph, 1);
    run(INC_A, 49, 1, 0); run(INC_B, 10, 1, 0);
    flush(); pin(8);

    // tolerance edge, -2^31 difference, zero increment
    do_reset(); pin(9);
    ph = $urandom; send(ph, 0);
    run(32'h1000_0000, 5, 0, 0);
    run(32'h1000_0000 + TOL, 5, 0, 0);
    run(32'h1000_0000 + TOL + 32'd1, 5, 0, 0);
    run(32'h9001_0001, 5, 0, 0);
    run(32'h0000_0000, 5, 0, 0);
    run(32'h1000_0000, 2, 0, 0);
    flush(); pin(10);

    // reset in the middle of a dwell
    do_reset();
    ph = $urandom; send(ph, 0);
    run(INC_A, 30, 0, 0);
    do_reset(); pin(11);
    run(INC_A, 30, 0, 0); run(INC_C, 5, 0, 0);
    flush(); pin(12);

    // random dwells with gaps, jitter and occasional resets
    do_reset();
    ph = $urandom; send(ph, 0);
    prev_inc = $urandom;
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 5))
        0: inc = $urandom;
        1: inc = prev_inc + TOL;
        2: inc = prev_inc + TOL + 32'd1;
        3: inc = prev_inc - TOL - 32'd1;
        4: inc = 32'd0;
        default: inc = prev_inc ^ 32'h8000_0000;
      endcase
      run(inc, int'($urandom_range(1, 25)), -1, ($urandom_range(0, 1) == 1) ? 32'h40 : 0);
      prev_inc = inc;
      if ($urandom_range(0, 14) == 0) do_reset();
    end
    flush();

    @(negedge clk);
    tb_done = 1'b1;
  end
endmodule
